// File: rtl/key_probe_pkg.sv
// Shared types and default sizing for the key prober and its byte assembler.
package key_probe_pkg;

  localparam int DEF_KEY_BYTES    = 4;
  localparam int DEF_RESP_LATENCY = 1;
  localparam int DEF_MAX_FAILS    = 3;
  localparam int DEF_LOCK_CYCLES  = 16;

  localparam int KEY_W = 8 * DEF_KEY_BYTES;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WAIT    = 2'd1,
    REPORT  = 2'd2,
    LOCK    = 2'd3
  } state_e;

endpackage

// File: rtl/key_shift_asm.sv
// Byte-serial key assembler: shifts bytes in MSB first and flags the byte that completes a key.
module key_shift_asm
  import key_probe_pkg::*;
#(
  parameter int KEY_BYTES = DEF_KEY_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_byte,
  input  logic                   byte_en,
  output logic [8*KEY_BYTES-1:0] key,
  output logic                   done
);

  localparam int KW = 8 * KEY_BYTES;
  localparam int CW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  logic [KW-1:0] shreg;
  logic [CW-1:0] cnt;

  // key is the shift result including the byte on the bus, so the owner can latch it on the done edge
  assign key  = (shreg << 8) | KW'(in_byte);
  assign done = byte_en && (cnt == CW'(KEY_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (byte_en) begin
      shreg <= key;
      cnt   <= done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_prober.sv
// Presents assembled keys to a registered checker, reports the response, and locks out after repeated misses.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  COLLECT | accepting key bytes; key_out holds the previous key
//  WAIT    | key_out presented, counting checker latency before capture
//  REPORT  | result held on res_* until res_ready handshake
//  LOCK    | too many consecutive misses; inputs refused for LOCK_CYCLES
module key_prober
  import key_probe_pkg::*;
#(
  parameter int KEY_BYTES    = DEF_KEY_BYTES,
  parameter int RESP_LATENCY = DEF_RESP_LATENCY,
  parameter int MAX_FAILS    = DEF_MAX_FAILS,
  parameter int LOCK_CYCLES  = DEF_LOCK_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [8*KEY_BYTES-1:0] key_out,
  input  logic [8*KEY_BYTES-1:0] data_in,
  output logic [8*KEY_BYTES-1:0] res_data,
  output logic                   res_hit,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   locked
);

  localparam int KW     = 8 * KEY_BYTES;
  localparam int WAIT_W = (RESP_LATENCY > 0) ? $clog2(RESP_LATENCY + 1) : 1;
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

  state_e            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [FAIL_W-1:0] fail_cnt;
  logic [FAIL_W-1:0] fail_next;
  logic [LOCK_W-1:0] lock_cnt;
  logic              byte_en;
  logic [KW-1:0]     asm_key;
  logic              asm_done;

  assign in_ready  = (state == COLLECT);
  assign byte_en   = in_valid && in_ready;
  assign fail_next = fail_cnt + 1'b1;

  key_shift_asm #(
    .KEY_BYTES (KEY_BYTES)
  ) u_asm (
    .clk     (clk),
    .rst     (rst),
    .in_byte (in_data),
    .byte_en (byte_en),
    .key     (asm_key),
    .done    (asm_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      key_out   <= '0;
      res_data  <= '0;
      res_hit   <= 1'b0;
      res_valid <= 1'b0;
      locked    <= 1'b0;
      wait_cnt  <= '0;
      fail_cnt  <= '0;
      lock_cnt  <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (asm_done) begin
            key_out  <= asm_key;
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // capture lands RESP_LATENCY+1 edges after the key_out update
          if (wait_cnt == WAIT_W'(RESP_LATENCY)) begin
            res_data  <= data_in;
            res_hit   <= |data_in;
            res_valid <= 1'b1;
            state     <= REPORT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (res_hit) begin
              fail_cnt <= '0;
              state    <= COLLECT;
            end else if (fail_next == FAIL_W'(MAX_FAILS)) begin
              fail_cnt <= '0;
              locked   <= 1'b1;
              lock_cnt <= LOCK_W'(LOCK_CYCLES);
              state    <= LOCK;
            end else begin
              fail_cnt <= fail_next;
              state    <= COLLECT;
            end
          end
        end
        LOCK: begin
          // releasing on the 1->0 step keeps locked high for exactly LOCK_CYCLES cycles
          lock_cnt <= lock_cnt - 1'b1;
          if (lock_cnt == LOCK_W'(1)) begin
            locked <= 1'b0;
            state  <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_key_prober.sv
// Self-checking bench for key_prober against a registered unlock checker and a transaction-level model.
module tb_key_prober;

  localparam logic [31:0] GOOD_KEY  = 32'h4C6F7452;
  localparam logic [31:0] GOOD_DATA = 32'h00464C45;
  localparam int          LATENCY   = 2;
  localparam int          LOCK_LEN  = 16;
  localparam int          MAX_MISS  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] key_out;
  logic [31:0] data_in = 32'h0;
  logic [31:0] res_data;
  logic        res_hit;
  logic        res_valid;
  logic        res_ready;
  logic        locked;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int          miss_run = 0;
  logic [31:0] exp_key  = 32'h0;

  always #5 clk = ~clk;

  always @(posedge clk) data_in <= (key_out == GOOD_KEY) ? GOOD_DATA : 32'h0;

  key_prober dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key_out   (key_out),
    .data_in   (data_in),
    .res_data  (res_data),
    .res_hit   (res_hit),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .locked    (locked)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] checker_resp(input logic [31:0] k);
    return (k == GOOD_KEY) ? GOOD_DATA : 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    res_ready = 1'b0;
    tick();
    tick();
    check("rst_key_out", key_out, 32'h0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, 32'h0);
    check("rst_res_hit", res_hit, 1'b0);
    check("rst_locked", locked, 1'b0);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    miss_run = 0;
    exp_key  = 32'h0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("in_ready_timeout", (n < 100), 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_key(input logic [31:0] k, input int gap);
    int n;
    for (int i = 0; i < 4; i++) begin
      if (i > 0 && gap > 0) repeat ($urandom_range(0, gap)) tick();
      send_byte(k[31 - 8*i -: 8]);
      if (i < 3) check("no_partial_key", key_out, exp_key);
      else       check("key_out", key_out, k);
    end
    exp_key = k;
    n = 0;
    while (!res_valid && n < 20) begin
      check("wait_in_ready", in_ready, 1'b0);
      tick();
      n++;
    end
    check("resp_latency", n, LATENCY);
    check("res_data", res_data, checker_resp(k));
    check("res_hit", res_hit, (checker_resp(k) != 0));
  endtask

  task automatic do_report(input int hold, input logic pre_en, input logic [7:0] pre_byte);
    int n;
    logic [31:0] held = checker_resp(exp_key);
    if (pre_en) begin
      in_valid = 1'b1;
      in_data  = pre_byte;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_res_valid", res_valid, 1'b1);
      check("hold_res_data", res_data, held);
      check("hold_in_ready", in_ready, 1'b0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("handshake_res_valid", res_valid, 1'b0);
    if (held != 0) miss_run = 0;
    else           miss_run++;
    if (miss_run == MAX_MISS) begin
      miss_run = 0;
      check("lock_entry", locked, 1'b1);
      n = 0;
      while (locked && n < 100) begin
        check("lock_in_ready", in_ready, 1'b0);
        tick();
        n++;
      end
      check("lock_len", n, LOCK_LEN);
      check("post_lock_in_ready", in_ready, 1'b1);
    end else begin
      check("no_lock", locked, 1'b0);
    end
  endtask

  function automatic logic [31:0] wrong_key();
    logic [31:0] k;
    do k = $urandom; while (k == GOOD_KEY);
    return k;
  endfunction

  initial begin
    do_reset();

    // 1: correct key back-to-back
    send_key(GOOD_KEY, 0);
    do_report(0, 1'b0, 8'h00);

    // 2: wrong key
    send_key(32'h00112233, 0);
    do_report(0, 1'b0, 8'h00);

    // 3: three misses -> lockout, then hit
    for (int i = 0; i < 2; i++) begin
      send_key(wrong_key(), 2);
      do_report($urandom_range(0, 2), 1'b0, 8'h00);
    end
    send_key(wrong_key(), 0);
    do_report(0, 1'b0, 8'h00);
    send_key(GOOD_KEY, 0);
    do_report(0, 1'b0, 8'h00);

    // 4: miss, miss, hit, miss, miss
    send_key(wrong_key(), 0);  do_report(0, 1'b0, 8'h00);
    send_key(wrong_key(), 0);  do_report(0, 1'b0, 8'h00);
    send_key(GOOD_KEY, 1);     do_report(0, 1'b0, 8'h00);
    send_key(wrong_key(), 0);  do_report(0, 1'b0, 8'h00);
    send_key(wrong_key(), 0);  do_report(0, 1'b0, 8'h00);

    // 5: long hold, first byte of next key offered during REPORT
    send_key(GOOD_KEY, 0);
    do_report(10, 1'b1, GOOD_KEY[31:24]);
    send_key(GOOD_KEY, 0);
    do_report(0, 1'b0, 8'h00);

    // 6: reset mid-key with one miss pending
    send_key(wrong_key(), 0);
    do_report(0, 1'b0, 8'h00);
    send_byte(8'h4C);
    send_byte(8'h6F);
    do_reset();
    send_key(wrong_key(), 0);  do_report(0, 1'b0, 8'h00);
    send_key(wrong_key(), 0);  do_report(0, 1'b0, 8'h00);
    send_key(GOOD_KEY, 0);     do_report(0, 1'b0, 8'h00);

    // random traffic
    for (int t = 0; t < 40; t++) begin
      logic [31:0] k;
      k = ($urandom_range(0, 2) == 0) ? GOOD_KEY : wrong_key();
      send_key(k, 3);
      do_report($urandom_range(0, 4), 1'b0, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d checks done", n_checks);
    $fatal(1);
  end

endmodule
